seq_stage_controller: RTL

Multi-cycle sequencer for the Y86-64 SEQ core. It steps one instruction through FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK and PC_UPDATE using one-hot stage enables. It owns the condition-code register that the Execute stage's ALU flags are written into, and it maintains processor status (stat). It sits above the Fetch/Decode/Execute/Memory/Writeback/PC blocks and gates their register updates.

---
 rtl/seq_stage_controller.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/seq_stage_controller.sv
// Multi-cycle stage sequencer for the Y86-64 SEQ core.
// Steps one instruction at a time through FETCH .. PC_UPDATE and drives
// one-hot stage enables that gate each stage's register updates. It owns
// the condition-code register and the processor status. It also keeps
// retired-instruction and active-cycle counters.
module seq_stage_controller #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       icode,
  input  logic             instr_valid,
  input  logic             imem_error,
  input  logic             alu_zf,
  input  logic             alu_sf,
  input  logic             alu_of,
  input  logic             dmem_ready,
  input  logic             dmem_error,
  output logic             fetch_en,
  output logic             decode_en,
  output logic             execute_en,
  output logic             memory_en,
  output logic             writeback_en,
  output logic             pc_en,
  output logic             set_cc,
  output logic [2:0]       cc,
  output logic [2:0]       stat,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_PC_UPDATE = 3'd6,
    S_HALT      = 3'd7
  } state_t;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  // CC reset value: ZF set, SF and OF clear.
  localparam logic [2:0] CC_RESET = 3'b100;

  // Wait counter is 8 bits (timeout up to 255); compare in 9 bits so the
  // increment can never wrap before the limit check.
  localparam logic [8:0] TIMEOUT_LIM = 9'(MEM_TIMEOUT);

  localparam logic [3:0] ICODE_HALT = 4'h0;
  localparam logic [3:0] ICODE_OPQ  = 4'h6;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Instructions that touch data memory: rmmovq, mrmovq, call, ret, pushq, popq.
  function automatic logic is_mem_icode(input logic [3:0] ic);
    logic hit;
    case (ic)
      4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB: hit = 1'b1;
      default:                            hit = 1'b0;
    endcase
    return hit;
  endfunction

  // One-hot enable pattern {fetch,decode,execute,memory,writeback,pc}.
  function automatic logic [5:0] stage_onehot(input state_t s);
    logic [5:0] oh;
    case (s)
      S_FETCH:     oh = 6'b100000;
      S_DECODE:    oh = 6'b010000;
      S_EXECUTE:   oh = 6'b001000;
      S_MEMORY:    oh = 6'b000100;
      S_WRITEBACK: oh = 6'b000010;
      S_PC_UPDATE: oh = 6'b000001;
      default:     oh = 6'b000000;
    endcase
    return oh;
  endfunction

  state_t           state_q, state_d;
  logic [5:0]       en_q, en_d;
  logic [2:0]       cc_q, cc_d;
  logic [2:0]       stat_q, stat_d;
  logic             halted_q, halted_d;
  logic [7:0]       wait_q, wait_d;
  logic [CNT_W-1:0] instr_q, instr_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic             running;
  logic             set_cc_w;

  // Only OPq writes the condition codes, and only in its EXECUTE cycle.
  assign set_cc_w = (state_q == S_EXECUTE) && (icode == ICODE_OPQ);
  assign running  = (state_q != S_IDLE) && (state_q != S_HALT);

  // Next-state, status, CC and counter logic.
  always_comb begin
    state_d  = state_q;
    stat_d   = stat_q;
    cc_d     = cc_q;
    wait_d   = wait_q;
    instr_d  = instr_q;
    cycle_d  = running ? (cycle_q + CNT_ONE) : cycle_q;

    if (set_cc_w) begin
      cc_d = {alu_zf, alu_sf, alu_of};
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        // Address fault outranks an illegal instruction, which outranks halt.
        if (imem_error) begin
          stat_d  = STAT_ADR;
          state_d = S_HALT;
        end else if (!instr_valid) begin
          stat_d  = STAT_INS;
          state_d = S_HALT;
        end else if (icode == ICODE_HALT) begin
          stat_d  = STAT_HLT;
          state_d = S_HALT;
        end else begin
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = S_EXECUTE;
      end
      S_EXECUTE: begin
        if (is_mem_icode(icode)) begin
          state_d = S_MEMORY;
          wait_d  = 8'd0;
        end else begin
          state_d = S_WRITEBACK;
        end
      end
      S_MEMORY: begin
        // dmem_error only means something once the access has completed.
        if (dmem_ready) begin
          if (dmem_error) begin
            stat_d  = STAT_ADR;
            state_d = S_HALT;
          end else begin
            state_d = S_WRITEBACK;
          end
        end else if (({1'b0, wait_q} + 9'd1) >= TIMEOUT_LIM) begin
          stat_d  = STAT_ADR;
          state_d = S_HALT;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_WRITEBACK: begin
        state_d = S_PC_UPDATE;
      end
      S_PC_UPDATE: begin
        instr_d = instr_q + CNT_ONE;
        state_d = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    en_d     = stage_onehot(state_d);
    halted_d = (state_d == S_HALT);
  end

  // State, enables and architectural status registers with async reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      en_q     <= 6'b000000;
      cc_q     <= CC_RESET;
      stat_q   <= STAT_AOK;
      halted_q <= 1'b0;
      wait_q   <= 8'd0;
      instr_q  <= '0;
      cycle_q  <= '0;
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      cc_q     <= cc_d;
      stat_q   <= stat_d;
      halted_q <= halted_d;
      wait_q   <= wait_d;
      instr_q  <= instr_d;
      cycle_q  <= cycle_d;
    end
  end

  assign fetch_en     = en_q[5];
  assign decode_en    = en_q[4];
  assign execute_en   = en_q[3];
  assign memory_en    = en_q[2];
  assign writeback_en = en_q[1];
  assign pc_en        = en_q[0];
  assign set_cc       = set_cc_w;
  assign cc           = cc_q;
  assign stat         = stat_q;
  assign halted       = halted_q;
  assign instr_count  = instr_q;
  assign cycle_count  = cycle_q;

endmodule
